// File: rtl/lcd_spi_stream_master.sv
// rtl/lcd_spi_stream_master.sv - buffered SPI mode-0 word master with panel reset sequencer
// Optional receive path: define LCD_SPI_READBACK_EN to add o_rx_data/o_rx_valid.
module lcd_spi_stream_master #(
    parameter int DATA_W       = 8,
    parameter int CLK_DIV      = 2,
    parameter int FIFO_DEPTH   = 16,
    parameter int RST_LOW_CYC  = 1000,
    parameter int RST_WAIT_CYC = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_dc,
    input  logic              i_last,
    output logic              o_ready,
    input  logic              i_hw_rst_req,
    output logic              o_hw_rst_done,
    output logic              o_word_done,
    output logic              o_busy,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs,
    output logic              dc,
    output logic              o_lcd_reset
`ifdef LCD_SPI_READBACK_EN
    ,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid
`endif
);

    localparam int W_W     = DATA_W + 2;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int PH_W    = $clog2(2 * CLK_DIV);
    localparam int BI_W    = $clog2(DATA_W);
    localparam int RST_MAX = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int RC_W    = (RST_MAX > 1) ? $clog2(RST_MAX) : 1;

    localparam logic [PH_W-1:0] PH_EDGE_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE      = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST      = PH_W'(2 * CLK_DIV - 1);
    localparam logic [BI_W-1:0] BIT_MSB      = BI_W'(DATA_W - 1);
    localparam logic [RC_W-1:0] RC_LOW_LAST  = RC_W'(RST_LOW_CYC - 1);
    localparam logic [RC_W-1:0] RC_WAIT_LAST = RC_W'(RST_WAIT_CYC - 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, RST_LOW, RST_WAIT} state_t;

    // Input FIFO: entries are {last, dc, data}
    logic [W_W-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, push, pop;
    logic [W_W-1:0]    head;
    logic              head_last, head_dc;
    logic [DATA_W-1:0] head_data;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign o_ready   = !full;
    assign push      = i_valid && !full;
    assign head      = mem[rd_ptr];
    assign head_last = head[W_W-1];
    assign head_dc   = head[W_W-2];
    assign head_data = head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {i_last, i_dc, i_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    state_t            state, state_n;
    logic [PH_W-1:0]   ph, ph_n, ph_inc;
    logic [BI_W-1:0]   bit_idx, bit_n;
    logic [DATA_W-1:0] shreg, sh_n;
    logic              cur_last, last_n;
    logic [RC_W-1:0]   rst_cnt, rc_n;
    logic              rst_pend, take_rst;
    logic              cs_q, sclk_q, mosi_q, dc_q, lcd_rst_q, word_done_q, hw_done_q;
    logic              cs_n, sclk_n, mosi_n, dc_n, lrst_n, wd_n, hd_n;
    logic              sample, word_end;

    assign ph_inc = ph + PH_W'(1);

    // Pin values are computed for the next cycle so every pin comes straight from a flop.
    always_comb begin
        state_n  = state;
        ph_n     = ph;
        bit_n    = bit_idx;
        sh_n     = shreg;
        last_n   = cur_last;
        rc_n     = rst_cnt;
        cs_n     = cs_q;
        sclk_n   = sclk_q;
        mosi_n   = mosi_q;
        dc_n     = dc_q;
        lrst_n   = lcd_rst_q;
        wd_n     = 1'b0;
        hd_n     = 1'b0;
        pop      = 1'b0;
        take_rst = 1'b0;
        sample   = 1'b0;
        word_end = 1'b0;
        case (state)
            IDLE: begin
                if (rst_pend) begin
                    state_n  = RST_LOW;
                    rc_n     = '0;
                    lrst_n   = 1'b0;
                    take_rst = 1'b1;
                end else if (!empty) begin
                    pop     = 1'b1;
                    state_n = CS_SETUP;
                    ph_n    = '0;
                    cs_n    = 1'b0;
                    sclk_n  = 1'b0;
                    dc_n    = head_dc;
                    sh_n    = head_data;
                    last_n  = head_last;
                    bit_n   = BIT_MSB;
                    mosi_n  = head_data[DATA_W-1];
                end
            end
            CS_SETUP: begin
                if (ph == PH_EDGE_LAST) begin
                    state_n = SHIFT;
                    ph_n    = '0;
                end else begin
                    ph_n = ph_inc;
                end
            end
            SHIFT: begin
                sample = (ph == PH_RISE);
                if (ph == PH_LAST) begin
                    sclk_n = 1'b0;
                    ph_n   = '0;
                    if (bit_idx == '0) begin
                        wd_n     = 1'b1;
                        word_end = 1'b1;
                        // Chain the next word without releasing CS when the burst continues
                        if (!cur_last && !empty) begin
                            pop    = 1'b1;
                            dc_n   = head_dc;
                            sh_n   = head_data;
                            last_n = head_last;
                            bit_n  = BIT_MSB;
                            mosi_n = head_data[DATA_W-1];
                        end else begin
                            state_n = CS_HOLD;
                        end
                    end else begin
                        bit_n  = bit_idx - BI_W'(1);
                        sh_n   = {shreg[DATA_W-2:0], 1'b0};
                        mosi_n = shreg[DATA_W-2];
                    end
                end else begin
                    ph_n   = ph_inc;
                    sclk_n = (ph_inc >= PH_RISE);
                end
            end
            CS_HOLD: begin
                if (ph == PH_EDGE_LAST) begin
                    state_n = IDLE;
                    cs_n    = 1'b1;
                    mosi_n  = 1'b0;
                end else begin
                    ph_n = ph_inc;
                end
            end
            RST_LOW: begin
                if (rst_cnt == RC_LOW_LAST) begin
                    state_n = RST_WAIT;
                    rc_n    = '0;
                    lrst_n  = 1'b1;
                end else begin
                    rc_n = rst_cnt + RC_W'(1);
                end
            end
            RST_WAIT: begin
                if (rst_cnt == RC_WAIT_LAST) begin
                    state_n = IDLE;
                    hd_n    = 1'b1;
                end else begin
                    rc_n = rst_cnt + RC_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ph          <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            cur_last    <= 1'b0;
            rst_cnt     <= '0;
            rst_pend    <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            dc_q        <= 1'b0;
            lcd_rst_q   <= 1'b1;
            word_done_q <= 1'b0;
            hw_done_q   <= 1'b0;
        end else begin
            state       <= state_n;
            ph          <= ph_n;
            bit_idx     <= bit_n;
            shreg       <= sh_n;
            cur_last    <= last_n;
            rst_cnt     <= rc_n;
            cs_q        <= cs_n;
            sclk_q      <= sclk_n;
            mosi_q      <= mosi_n;
            dc_q        <= dc_n;
            lcd_rst_q   <= lrst_n;
            word_done_q <= wd_n;
            hw_done_q   <= hd_n;
            // Requests arriving while the sequence runs are deliberately dropped
            if (take_rst)
                rst_pend <= 1'b0;
            else if (i_hw_rst_req && state != RST_LOW && state != RST_WAIT)
                rst_pend <= 1'b1;
        end
    end

    assign cs            = cs_q;
    assign sclk          = sclk_q;
    assign mosi          = mosi_q;
    assign dc            = dc_q;
    assign o_lcd_reset   = lcd_rst_q;
    assign o_word_done   = word_done_q;
    assign o_hw_rst_done = hw_done_q;
    assign o_busy        = (state != IDLE) || !empty;

`ifdef LCD_SPI_READBACK_EN
    logic [DATA_W-1:0] rx_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sh      <= '0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            if (sample) rx_sh <= {rx_sh[DATA_W-2:0], miso};
            o_rx_valid <= word_end;
            if (word_end) o_rx_data <= rx_sh;
        end
    end

    logic unused_ok;
    assign unused_ok = shreg[DATA_W-1];
`else
    logic unused_ok;
    assign unused_ok = ^{miso, sample, word_end, shreg[DATA_W-1]};
`endif

endmodule
